hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_pkg.sv | 16 +
 rtl/hazard_sb_entry.sv | 59 +++++
 rtl/hazard_scoreboard.sv | 85 ++++++++
 tb/tb_hazard_scoreboard.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared constants and entry type for the register hazard scoreboard.
package hazard_pkg;

    localparam int unsigned NREG_DEF  = 32;
    localparam int unsigned LAT_W_DEF = 3;

    // All-ones latency: result arrives on an external ld_done event.
    localparam logic [LAT_W_DEF-1:0] LAT_WAIT = '1;

    // Per-register scoreboard state at the default latency width.
    typedef struct packed {
        logic                 pending;
        logic [LAT_W_DEF-1:0] cnt;
    } sb_entry_t;

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard entry: pending bit plus latency countdown.
// Ports:
//   clk, rstn     clock, async active-low reset
//   issue         an instruction writing this register is accepted
//   issue_lat     latency loaded on issue (all-ones = wait for ld_done)
//   wb_hit        write-back of this register completes
//   ld_hit        variable-latency result for this register is forwardable
//   pending       registered outstanding-write flag
//   busy_c        pending and not yet forwardable (combinational)
module hazard_sb_entry #(
    parameter int unsigned LAT_W = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             issue,
    input  logic [LAT_W-1:0] issue_lat,
    input  logic             wb_hit,
    input  logic             ld_hit,
    output logic             pending,
    output logic             busy_c
);

    localparam logic [LAT_W-1:0] CNT_WAIT = '1;

    logic [LAT_W-1:0] cnt;
    logic             pending_nxt;
    logic [LAT_W-1:0] cnt_nxt;

    // Update priority: issue, then write-back, then load-done, then countdown.
    always_comb begin
        pending_nxt = pending;
        cnt_nxt     = cnt;
        if (issue) begin
            pending_nxt = 1'b1;
            cnt_nxt     = issue_lat;
        end else if (wb_hit) begin
            pending_nxt = 1'b0;
            cnt_nxt     = '0;
        end else if (ld_hit && pending) begin
            cnt_nxt     = '0;
        end else if (pending && cnt != '0 && cnt != CNT_WAIT) begin
            cnt_nxt     = cnt - LAT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pending <= 1'b0;
            cnt     <= '0;
        end else begin
            pending <= pending_nxt;
            cnt     <= cnt_nxt;
        end
    end

    // cnt==0 means the value is forwardable, so only a nonzero count blocks.
    assign busy_c = pending && (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard: tracks outstanding writes and raises stall on
// RAW/WAW hazards against results that are not yet forwardable.
// Ports:
//   clk, rstn                  clock, async active-low reset
//   id_valid                   instruction present in ID
//   id_rs, id_rs_used          source addresses and per-channel read flags
//   id_rd, id_we, id_lat       destination, write enable, result latency
//   ld_done, ld_rd             variable-latency result now forwardable
//   wb_valid, wb_rd            write-back completes this cycle
//   stall                      freeze IF/ID, bubble EX (combinational)
//   pending                    per-register outstanding-write mask
//   stall_cnt                  saturating count of stalled cycles
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter  int unsigned NREG  = NREG_DEF,
    parameter  int unsigned NSRC  = 2,
    parameter  int unsigned LAT_W = LAT_W_DEF,
    localparam int unsigned AW    = $clog2(NREG)
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     id_valid,
    input  logic [NSRC-1:0][AW-1:0]  id_rs,
    input  logic [NSRC-1:0]          id_rs_used,
    input  logic [AW-1:0]            id_rd,
    input  logic                     id_we,
    input  logic [LAT_W-1:0]         id_lat,
    input  logic                     ld_done,
    input  logic [AW-1:0]            ld_rd,
    input  logic                     wb_valid,
    input  logic [AW-1:0]            wb_rd,
    output logic                     stall,
    output logic [NREG-1:0]          pending,
    output logic [31:0]              stall_cnt
);

    logic [NREG-1:0] busy;
    logic            raw;
    logic            waw;
    logic            issue_ok;

    // x0 is hardwired: never pending, never busy.
    assign pending[0] = 1'b0;
    assign busy[0]    = 1'b0;

    for (genvar i = 1; i < NREG; i++) begin : g_entry
        hazard_sb_entry #(
            .LAT_W (LAT_W)
        ) u_entry (
            .clk       (clk),
            .rstn      (rstn),
            .issue     (issue_ok && (id_rd == AW'(i))),
            .issue_lat (id_lat),
            .wb_hit    (wb_valid && (wb_rd == AW'(i))),
            .ld_hit    (ld_done && (ld_rd == AW'(i))),
            .pending   (pending[i]),
            .busy_c    (busy[i])
        );
    end

    // Hazard detection sees only registered state; ld_done/wb land next cycle.
    always_comb begin
        raw = 1'b0;
        for (int k = 0; k < NSRC; k++) begin
            if (id_rs_used[k] && (id_rs[k] != '0) && busy[id_rs[k]]) begin
                raw = 1'b1;
            end
        end
        waw   = id_we && (id_rd != '0) && busy[id_rd];
        stall = id_valid && (raw || waw);
    end

    assign issue_ok = id_valid && id_we && (id_rd != '0) && !stall;

    // Saturating stall-cycle counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: rule-level reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    localparam int unsigned NREG  = 32;
    localparam int unsigned NSRC  = 2;
    localparam int unsigned LAT_W = 3;
    localparam int unsigned AW    = 5;

    logic                    clk = 1'b0;
    logic                    rstn;
    logic                    id_valid;
    logic [NSRC-1:0][AW-1:0] id_rs;
    logic [NSRC-1:0]         id_rs_used;
    logic [AW-1:0]           id_rd;
    logic                    id_we;
    logic [LAT_W-1:0]        id_lat;
    logic                    ld_done;
    logic [AW-1:0]           ld_rd;
    logic                    wb_valid;
    logic [AW-1:0]           wb_rd;
    logic                    stall;
    logic [NREG-1:0]         pending;
    logic [31:0]             stall_cnt;

    int total = 0;
    int bad   = 0;

    hazard_scoreboard #(.NREG(NREG), .NSRC(NSRC), .LAT_W(LAT_W)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rs_used (id_rs_used),
        .id_rd      (id_rd),
        .id_we      (id_we),
        .id_lat     (id_lat),
        .ld_done    (ld_done),
        .ld_rd      (ld_rd),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .stall      (stall),
        .pending    (pending),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: outstanding flag and remaining cycles until
    // forwardable per register; -1 means "until ld_done".
    bit     m_pend [NREG];
    int     m_rem  [NREG];
    longint m_scnt;

    function automatic bit blocks(int r);
        return (r != 0) && m_pend[r] && (m_rem[r] != 0);
    endfunction

    function automatic bit model_stall();
        bit h = 0;
        if (!id_valid) return 0;
        for (int k = 0; k < NSRC; k++)
            if (id_rs_used[k] && blocks(int'(id_rs[k]))) h = 1;
        if (id_we && blocks(int'(id_rd))) h = 1;
        return h;
    endfunction

    function automatic logic [NREG-1:0] model_pend();
        logic [NREG-1:0] v = '0;
        for (int r = 0; r < NREG; r++) v[r] = m_pend[r];
        return v;
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int r = 0; r < NREG; r++) begin
                m_pend[r] = 0;
                m_rem[r]  = 0;
            end
            m_scnt = 0;
        end else begin
            bit st;
            bit iss;
            st  = model_stall();
            iss = id_valid && id_we && (id_rd != 0) && !st;
            for (int r = 1; r < NREG; r++) begin
                if (iss && int'(id_rd) == r) begin
                    m_pend[r] = 1;
                    m_rem[r]  = (id_lat == LAT_WAIT) ? -1 : int'(id_lat);
                end else if (wb_valid && int'(wb_rd) == r) begin
                    m_pend[r] = 0;
                    m_rem[r]  = 0;
                end else if (ld_done && int'(ld_rd) == r && m_pend[r]) begin
                    m_rem[r]  = 0;
                end else if (m_pend[r] && m_rem[r] > 0) begin
                    m_rem[r]  = m_rem[r] - 1;
                end
            end
            if (st && m_scnt < 64'hFFFF_FFFF) m_scnt = m_scnt + 1;
        end
    end

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            cmp("model_stall", 64'(stall), 64'(model_stall()));
            cmp("model_pending", 64'(pending), 64'(model_pend()));
            cmp("model_stall_cnt", 64'(stall_cnt), 64'(m_scnt));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid   = 0;
        id_rs      = '0;
        id_rs_used = '0;
        id_rd      = '0;
        id_we      = 0;
        id_lat     = '0;
        ld_done    = 0;
        ld_rd      = '0;
        wb_valid   = 0;
        wb_rd      = '0;
    endtask

    task automatic issue(input int rd, input int lat);
        idle();
        id_valid = 1;
        id_we    = 1;
        id_rd    = AW'(rd);
        id_lat   = LAT_W'(lat);
    endtask

    task automatic read0(input int rs);
        idle();
        id_valid      = 1;
        id_rs[0]      = AW'(rs);
        id_rs_used[0] = 1;
    endtask

    task automatic retire(input int rd);
        idle();
        wb_valid = 1;
        wb_rd    = AW'(rd);
        tick();
        idle();
    endtask

    initial begin
        idle();
        rstn = 0;
        #1;
        cmp("rst_stall", 64'(stall), 64'd0);
        cmp("rst_pending", 64'(pending), 64'd0);
        cmp("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        tick(); tick();
        rstn = 1;
        tick();

        // RAW against a fixed-latency result of 2: two stalled cycles.
        issue(5, 2);
        @(negedge clk); cmp("t1_issue_stall", 64'(stall), 64'd0);
        tick();
        read0(5);
        @(negedge clk); cmp("t1_pend5", 64'(pending[5]), 64'd1);
        cmp("t1_stall_a", 64'(stall), 64'd1);
        tick();
        @(negedge clk); cmp("t1_stall_b", 64'(stall), 64'd1);
        tick();
        @(negedge clk); cmp("t1_stall_c", 64'(stall), 64'd0);
        cmp("t1_stall_cnt", 64'(stall_cnt), 64'd2);
        tick();
        idle();
        @(negedge clk); cmp("t1_pend_hold", 64'(pending[5]), 64'd1);
        tick();
        retire(5);
        @(negedge clk); cmp("t1_wb_clear", 64'(pending), 64'd0);
        tick();

        // Event-driven latency: stall held until ld_done, no same-cycle bypass.
        issue(7, int'(LAT_WAIT));
        tick();
        read0(7);
        for (int i = 0; i < 10; i++) begin
            if (i == 9) begin
                ld_done = 1;
                ld_rd   = AW'(7);
            end
            @(negedge clk); cmp("t2_wait_stall", 64'(stall), 64'd1);
            tick();
        end
        ld_done = 0;
        @(negedge clk); cmp("t2_released", 64'(stall), 64'd0);
        cmp("t2_stall_cnt", 64'(stall_cnt), 64'd12);
        tick();
        retire(7);

        // Writes to x0 are discarded.
        issue(0, 3);
        tick();
        read0(0);
        @(negedge clk); cmp("t3_x0_pend", 64'(pending), 64'd0);
        cmp("t3_x0_stall", 64'(stall), 64'd0);
        tick();

        // Issue beats a same-cycle write-back to the same register.
        issue(9, 2);
        wb_valid = 1;
        wb_rd    = AW'(9);
        tick();
        read0(9);
        @(negedge clk); cmp("t4_pend9", 64'(pending[9]), 64'd1);
        cmp("t4_stall_a", 64'(stall), 64'd1);
        tick();
        @(negedge clk); cmp("t4_stall_b", 64'(stall), 64'd1);
        tick();
        @(negedge clk); cmp("t4_stall_c", 64'(stall), 64'd0);
        cmp("t4_stall_cnt", 64'(stall_cnt), 64'd14);
        tick();
        retire(9);

        // WAW against an event-driven write, then reissue with a reloaded count.
        issue(3, int'(LAT_WAIT));
        tick();
        issue(3, 1);
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                ld_done = 1;
                ld_rd   = AW'(3);
            end
            @(negedge clk); cmp("t5_waw_stall", 64'(stall), 64'd1);
            tick();
        end
        ld_done = 0;
        @(negedge clk); cmp("t5_waw_accept", 64'(stall), 64'd0);
        tick();
        read0(3);
        @(negedge clk); cmp("t5_reload_stall", 64'(stall), 64'd1);
        tick();
        @(negedge clk); cmp("t5_reload_done", 64'(stall), 64'd0);
        cmp("t5_stall_cnt", 64'(stall_cnt), 64'd18);
        tick();
        retire(3);

        // Only channels flagged as used participate.
        issue(6, 2);
        tick();
        idle();
        id_valid = 1;
        id_rs[0] = AW'(6);
        id_rs[1] = AW'(6);
        @(negedge clk); cmp("t6_unused_ch", 64'(stall), 64'd0);
        tick();
        id_rs_used = 2'b10;
        @(negedge clk); cmp("t6_ch1_stall", 64'(stall), 64'd1);
        tick();
        @(negedge clk); cmp("t6_ch1_done", 64'(stall), 64'd0);
        tick();
        retire(6);

        // Invalid ID never stalls; reset mid-countdown wipes everything.
        issue(4, 3);
        tick();
        read0(4);
        id_valid = 0;
        @(negedge clk); cmp("t7_invalid_nostall", 64'(stall), 64'd0);
        tick();
        id_valid = 1;
        @(negedge clk); cmp("t7_stall", 64'(stall), 64'd1);
        tick();
        @(negedge clk);
        #2 rstn = 0;
        #1;
        cmp("t7_rst_pending", 64'(pending), 64'd0);
        cmp("t7_rst_stall", 64'(stall), 64'd0);
        cmp("t7_rst_stall_cnt", 64'(stall_cnt), 64'd0);
        tick();
        rstn = 1;
        @(negedge clk); cmp("t7_post_rst_stall", 64'(stall), 64'd0);
        tick();
        idle();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
